fifo_ctrl: RTL and testbench

Pointer/flag controller that sequences a 16x4 simple dual-port synchronous RAM as a FIFO for the TLP buffering path. It turns push/pop requests into RAM write-port and read-port strobes and addresses, and tracks occupancy. It also generates full/empty/almost flags and reports overflow/underflow. The RAM itself is external; this block owns all sequencing of it.

---
 rtl/fifo_ctrl_if.sv | 40 ++++
 rtl/fifo_ctrl.sv | 116 +++++++++++
 tb/tb_fifo_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_if.sv
// Request/RAM/status bundle between a FIFO user plus its RAM (master side)
// and the fifo_ctrl sequencer (slave side).
interface fifo_ctrl_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
);
    logic              flush_i;
    logic              push_i;
    logic [DATA_W-1:0] data_i;
    logic              pop_i;
    logic              ram_we_a;
    logic [ADDR_W-1:0] ram_addr_a;
    logic [DATA_W-1:0] ram_data_a;
    logic              ram_re_b;
    logic [ADDR_W-1:0] ram_addr_b;
    logic [DATA_W-1:0] ram_q_b;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow_err;
    logic              underflow_err;

    modport master (
        output flush_i, push_i, data_i, pop_i, ram_q_b,
        input  ram_we_a, ram_addr_a, ram_data_a, ram_re_b, ram_addr_b,
               data_o, valid_o, count, full, empty, almost_full, almost_empty,
               overflow_err, underflow_err
    );

    modport slave (
        input  flush_i, push_i, data_i, pop_i, ram_q_b,
        output ram_we_a, ram_addr_a, ram_data_a, ram_re_b, ram_addr_b,
               data_o, valid_o, count, full, empty, almost_full, almost_empty,
               overflow_err, underflow_err
    );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/flag sequencer driving an external 16x4 dual-port RAM as a FIFO.
// Define FIFO_ERR_HALT_EN to halt in ERR on overflow/underflow with sticky errors.
module fifo_ctrl #(
    parameter int DATA_W    = 4,
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 3
) (
    input logic        clk,
    input logic        reset_L,
    fifo_ctrl_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_AF   = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] CNT_AE   = (ADDR_W+1)'(AE_THRESH);

    typedef enum logic [1:0] {S_INIT, S_RUN, S_ERR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count_q, count_nxt;
    logic              full_q, empty_q, af_q, ae_q;
    logic              valid_q, ovf_q, udf_q;
    logic              run, push_acc, pop_acc, ovf_req, udf_req;

    // Flush outranks everything, so it masks acceptance and errors alike.
    always_comb begin
        run      = (state == S_RUN) && !bus.flush_i;
        pop_acc  = run && bus.pop_i && !empty_q;
        push_acc = run && bus.push_i && (!full_q || pop_acc);
        ovf_req  = run && bus.push_i && full_q && !pop_acc;
        udf_req  = run && bus.pop_i && empty_q;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT: state_nxt = S_RUN;
            S_RUN: begin
`ifdef FIFO_ERR_HALT_EN
                if (ovf_req || udf_req) state_nxt = S_ERR;
`endif
            end
            S_ERR:   if (bus.flush_i) state_nxt = S_RUN;
            default: state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        count_nxt = count_q;
        if (bus.flush_i)
            count_nxt = '0;
        else if (push_acc && !pop_acc)
            count_nxt = count_q + 1'b1;
        else if (pop_acc && !push_acc)
            count_nxt = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) state <= S_INIT;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (bus.flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_acc) wr_ptr <= wr_ptr + 1'b1;
                if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
            end
            // Flags track next count so they agree with count on every cycle.
            count_q <= count_nxt;
            full_q  <= (count_nxt == CNT_FULL);
            empty_q <= (count_nxt == '0);
            af_q    <= (count_nxt >= CNT_AF);
            ae_q    <= (count_nxt <= CNT_AE);
            valid_q <= pop_acc;
`ifdef FIFO_ERR_HALT_EN
            ovf_q   <= !bus.flush_i && (ovf_q || ovf_req);
            udf_q   <= !bus.flush_i && (udf_q || udf_req);
`else
            ovf_q   <= ovf_req;
            udf_q   <= udf_req;
`endif
        end
    end

    assign bus.ram_we_a      = push_acc;
    assign bus.ram_addr_a    = wr_ptr;
    assign bus.ram_data_a    = bus.data_i;
    assign bus.ram_re_b      = pop_acc;
    assign bus.ram_addr_b    = rd_ptr;
    assign bus.data_o        = bus.ram_q_b;
    assign bus.valid_o       = valid_q;
    assign bus.count         = count_q;
    assign bus.full          = full_q;
    assign bus.empty         = empty_q;
    assign bus.almost_full   = af_q;
    assign bus.almost_empty  = ae_q;
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = udf_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl with a behavioural read-before-write RAM.
module tb_fifo_ctrl;
    localparam int DW = 4, AW = 4, DEPTH = 16, AF = 12, AE = 3;

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    always #5 clk = ~clk;

    fifo_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
    fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW), .AF_THRESH(AF), .AE_THRESH(AE))
        dut (.clk(clk), .reset_L(reset_L), .bus(bus));

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_we_a) mem[bus.ram_addr_a] <= bus.ram_data_a;
        if (bus.ram_re_b) bus.ram_q_b <= mem[bus.ram_addr_b];
    end

    int n_chk = 0, n_fail = 0;

    bit            m_init, m_halt, exp_valid, exp_ovf, exp_udf;
    int            m_count;
    logic [AW-1:0] m_wr, m_rd;
    logic [DW-1:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic chk_regs();
        chk("count", 32'(bus.count), 32'(m_count));
        chk("full", 32'(bus.full), 32'(m_count == DEPTH));
        chk("empty", 32'(bus.empty), 32'(m_count == 0));
        chk("almost_full", 32'(bus.almost_full), 32'(m_count >= AF));
        chk("almost_empty", 32'(bus.almost_empty), 32'(m_count <= AE));
        chk("valid_o", 32'(bus.valid_o), 32'(exp_valid));
        if (exp_valid && sb.size() != 0) chk("data_o", 32'(bus.data_o), 32'(sb.pop_front()));
        chk("overflow_err", 32'(bus.overflow_err), 32'(exp_ovf));
        chk("underflow_err", 32'(bus.underflow_err), 32'(exp_udf));
    endtask

    task automatic model_reset();
        m_init = 1; m_halt = 0; exp_valid = 0; exp_ovf = 0; exp_udf = 0;
        m_count = 0; m_wr = '0; m_rd = '0;
        sb.delete();
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        bus.flush_i = 0; bus.push_i = 0; bus.pop_i = 0; bus.data_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 chk_regs();
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    // One clock: drive, check strobes mid-cycle, advance model, check registers.
    task automatic cyc(input bit f, input bit pu, input bit po, input logic [DW-1:0] d);
        bit run, pa, wa, ovf, udf;
        bus.flush_i = f; bus.push_i = pu; bus.pop_i = po; bus.data_i = d;
        run = !m_init && !m_halt && !f;
        pa  = run && po && (m_count != 0);
        wa  = run && pu && ((m_count != DEPTH) || pa);
        ovf = run && pu && (m_count == DEPTH) && !pa;
        udf = run && po && (m_count == 0);
        #1;
        chk("ram_we_a", 32'(bus.ram_we_a), 32'(wa));
        chk("ram_re_b", 32'(bus.ram_re_b), 32'(pa));
        if (wa) begin
            chk("ram_addr_a", 32'(bus.ram_addr_a), 32'(m_wr));
            chk("ram_data_a", 32'(bus.ram_data_a), 32'(d));
        end
        if (pa) chk("ram_addr_b", 32'(bus.ram_addr_b), 32'(m_rd));
        @(posedge clk);
        if (m_init) begin
            m_init = 0; exp_valid = 0;
        end else if (f) begin
            m_count = 0; m_wr = '0; m_rd = '0; m_halt = 0;
            exp_valid = 0; exp_ovf = 0; exp_udf = 0;
            sb.delete();
        end else begin
            if (wa) begin sb.push_back(d); m_wr = m_wr + 1'b1; m_count++; end
            if (pa) begin m_rd = m_rd + 1'b1; m_count--; end
            exp_valid = pa;
`ifdef FIFO_ERR_HALT_EN
            exp_ovf = exp_ovf || ovf;
            exp_udf = exp_udf || udf;
            m_halt  = m_halt || ovf || udf;
`else
            exp_ovf = ovf;
            exp_udf = udf;
`endif
        end
        #1 chk_regs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ram_q_b = '0;
        do_reset();

        // INIT swallows the first push; the next one lands at address 0.
        cyc(0, 1, 0, 4'h5);
        cyc(0, 1, 0, 4'h6);
        chk("init_addr_next", 32'(bus.ram_addr_a), 32'd1);
        cyc(0, 0, 1, 4'h0);

        // Fill and drain.
        for (int i = 0; i < 16; i++) cyc(0, 1, 0, 4'(i + 1));
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, 4'h0);

        // Wrap from a flushed state: second batch wraps on its 7th write.
        cyc(1, 0, 0, 4'h0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 4'(i + 3));
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 4'h0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 4'(i + 7));

        // Top up to full, then push+pop on full, then drain (0xA comes last).
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 4'(i + 9));
        cyc(0, 1, 1, 4'hA);
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, 4'h0);

        // Underflow with a concurrent push, then a follow-up push.
        cyc(0, 1, 1, 4'h3);
        cyc(0, 1, 0, 4'h4);
        cyc(0, 0, 0, 4'h0);
        cyc(1, 0, 0, 4'h0);

        // Overflow.
        for (int i = 0; i < 16; i++) cyc(0, 1, 0, 4'(15 - i));
        cyc(0, 1, 0, 4'hE);
        cyc(0, 1, 0, 4'hD);
        cyc(0, 0, 1, 4'h0);
        cyc(1, 0, 0, 4'h0);
        cyc(0, 1, 0, 4'h2);
        cyc(0, 0, 1, 4'h0);

        // Async reset mid-cycle at count 7 with valid_o high.
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 4'(i));
        cyc(0, 0, 1, 4'h0);
        #2 reset_L = 1'b0;
        #1;
        chk("async_count", 32'(bus.count), 32'd0);
        chk("async_empty", 32'(bus.empty), 32'd1);
        chk("async_valid", 32'(bus.valid_o), 32'd0);
        do_reset();
        cyc(0, 1, 0, 4'h9);
        cyc(0, 1, 0, 4'h8);
        cyc(0, 0, 1, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
